// File: rtl/msfsm_pkg.sv
// rtl/msfsm_pkg.sv - shared types and helper functions for the MSFSM node
package msfsm_pkg;

   typedef enum logic {TK_IN = 1'b0, TK_OUT = 1'b1} trans_kind_e;

   // Widest one-hot vector the helper can build; place and event vectors must fit.
   localparam int OH_MAX_W = 64;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [OH_MAX_W-1:0] onehot(input int idx, input int w);
      logic [OH_MAX_W-1:0] v;
      v = '0;
      if (idx >= 0 && idx < w && idx < OH_MAX_W)
         v = {{(OH_MAX_W-1){1'b0}}, 1'b1} << idx;
      return v;
   endfunction

endpackage

// File: rtl/msfsm_prio_arb.sv
// rtl/msfsm_prio_arb.sv - fixed-priority arbiter, lowest request index wins
module msfsm_prio_arb
   import msfsm_pkg::*;
#(
   parameter int N  = 5,
   parameter int IW = clog2_min1(N)
)(
   input  logic [N-1:0]  i_req,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   // Two's-complement trick isolates the lowest set request bit.
   assign o_gnt = i_req & (~i_req + N'(1));
   assign o_any = |i_req;

   always_comb begin
      o_idx = '0;
      for (int i = 0; i < N; i++)
         if (o_gnt[i]) o_idx = IW'(i);
   end

endmodule

// File: rtl/msfsm_mealy_node_param.sv
// rtl/msfsm_mealy_node_param.sv - table-driven Mealy FSM node; MSFSM_ONEHOT_CHECK_EN enables place integrity checking
module msfsm_mealy_node_param
   import msfsm_pkg::*;
#(
   parameter int N_STATES    = 4,
   parameter int N_IN        = 4,
   parameter int N_OUT       = 1,
   parameter int N_PEERS     = 2,
   parameter int N_TRANS     = 5,
   parameter int RESET_STATE = 0,
   parameter logic [N_TRANS*clog2_min1(N_STATES)-1:0] TRANS_SRC =
      {2'd3, 2'd2, 2'd1, 2'd1, 2'd0},
   parameter logic [N_TRANS*clog2_min1(N_STATES)-1:0] TRANS_DST =
      {2'd0, 2'd3, 2'd2, 2'd2, 2'd1},
   parameter logic [N_TRANS-1:0] TRANS_KIND = 5'b01000,
   parameter logic [N_TRANS*clog2_min1((N_IN > N_OUT) ? N_IN : N_OUT)-1:0] TRANS_EVT =
      {2'd3, 2'd0, 2'd2, 2'd1, 2'd0},
   parameter logic [N_TRANS*N_PEERS-1:0] TRANS_TB_MASK =
      {2'b10, 2'b11, 2'b01, 2'b01, 2'b01},
   parameter int CW = 8
)(
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               en,
   input  logic [N_IN-1:0]                    in_evt,
   input  logic [N_TRANS*N_PEERS-1:0]         tb,
   output logic [N_STATES-1:0]                place,
   output logic [N_OUT-1:0]                   out_evt,
   output logic                               fired,
   output logic [clog2_min1(N_TRANS)-1:0]     fired_idx,
   output logic [CW-1:0]                      stall_cnt,
   output logic                               err
);

   localparam int SW = clog2_min1(N_STATES);
   localparam int EW = clog2_min1((N_IN > N_OUT) ? N_IN : N_OUT);
   localparam int TW = clog2_min1(N_TRANS);
   localparam int SP = 1 << SW;
   localparam int EP = 1 << EW;
   localparam logic [N_STATES-1:0] RST_OH = N_STATES'(onehot(RESET_STATE, N_STATES));

   logic [N_STATES-1:0] r_place;
   logic [CW-1:0]       r_stall;
   logic [SP-1:0]       w_place_pad;
   logic [EP-1:0]       w_in_pad;
   logic [EP-1:0]       w_out_pad;
   logic [N_TRANS-1:0]  w_req;
   logic [N_TRANS-1:0]  w_gnt;
   logic [TW-1:0]       w_idx;
   logic                w_any;
   logic                w_bad;
   logic [N_STATES-1:0] w_dst_oh;

   // Pad to full index range so table indices never select out of bounds.
   assign w_place_pad = SP'(r_place);
   assign w_in_pad    = EP'(in_evt);

   for (genvar t = 0; t < N_TRANS; t++) begin : g_trans
      logic [SW-1:0]      w_src;
      logic [EW-1:0]      w_evt;
      logic [N_PEERS-1:0] w_mask;
      logic [N_PEERS-1:0] w_tb;
      logic               w_tb_ok;
      logic               w_evt_ok;

      assign w_src    = TRANS_SRC[t*SW +: SW];
      assign w_evt    = TRANS_EVT[t*EW +: EW];
      assign w_mask   = TRANS_TB_MASK[t*N_PEERS +: N_PEERS];
      assign w_tb     = tb[t*N_PEERS +: N_PEERS];
      assign w_tb_ok  = &(w_tb | ~w_mask);
      assign w_evt_ok = (trans_kind_e'(TRANS_KIND[t]) == TK_OUT) | w_in_pad[w_evt];
      assign w_req[t] = en & ~reset & ~w_bad & w_place_pad[w_src] & w_tb_ok & w_evt_ok;
   end

   msfsm_prio_arb #(.N(N_TRANS), .IW(TW)) u_arb (
      .i_req (w_req),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   always_comb begin
      w_dst_oh  = r_place;
      w_out_pad = '0;
      for (int t = 0; t < N_TRANS; t++) begin
         if (w_gnt[t]) begin
            w_dst_oh = N_STATES'(onehot(int'(TRANS_DST[t*SW +: SW]), N_STATES));
            if (trans_kind_e'(TRANS_KIND[t]) == TK_OUT)
               w_out_pad = EP'(onehot(int'(TRANS_EVT[t*EW +: EW]), EP));
         end
      end
   end

`ifdef MSFSM_ONEHOT_CHECK_EN
   logic r_err;

   assign w_bad = (r_place == '0) | ((r_place & (r_place - N_STATES'(1))) != '0);

   always_ff @(posedge clk) begin
      if (reset)      r_err <= 1'b0;
      else if (w_bad) r_err <= 1'b1;
   end

   assign err = r_err;
`else
   assign w_bad = 1'b0;
   assign err   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset)      r_place <= RST_OH;
      else if (w_bad) r_place <= RST_OH;
      else if (w_any) r_place <= w_dst_oh;
   end

   always_ff @(posedge clk) begin
      if (reset || w_any)            r_stall <= '0;
      else if (en && r_stall != '1)  r_stall <= r_stall + CW'(1);
   end

   assign place     = r_place;
   assign out_evt   = w_out_pad[N_OUT-1:0];
   assign fired     = w_any;
   assign fired_idx = w_any ? w_idx : '0;
   assign stall_cnt = r_stall;

endmodule
